// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data memory with IDLE/WAIT/ACCESS/DONE handshake.
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_TRAP_EN.
module data_mem_responder #(
    parameter int DEPTH = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Req_valid,
    input  logic        Req_write,
    input  logic        Req_dw,
    input  logic        Req_byte,
    input  logic [31:0] Adrs,
    input  logic [31:0] Wdata,
    input  logic [63:0] Wdata64,
    output logic [31:0] Rdata,
    output logic [31:0] Rdata_next,
    output logic        Busy,
    output logic        Resp_valid,
    output logic        Resp_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;
    state_t state, state_d;
    logic [3:0] cnt, cnt_d;
    logic write_q, dw_q, byte_q, err_q, misalign, unused_adrs;
    logic [AW+1:0] adrs_q;
    logic [31:0] wdata_q;
    logic [63:0] wdata64_q;
    logic [AW-1:0] idx, idx_n;
    logic [31:0] mem [DEPTH];

    assign unused_adrs = ^Adrs[31:AW+2];
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = !(Req_write && Req_byte && !Req_dw) && Adrs[1:0] != 2'b00;
`else
    assign misalign = 1'b0;
`endif
    assign idx = adrs_q[AW+1:2];
    assign idx_n = idx + AW'(1);
    assign Busy = state != IDLE;
    assign Resp_valid = state == DONE;
    assign Resp_err = state == DONE && err_q;

    always_comb begin
        state_d = state;
        cnt_d = cnt;
        case (state)
            IDLE: if (Req_valid) begin
                state_d = misalign ? DONE : (WAIT_CYCLES == 0 ? ACCESS : WAIT);
                cnt_d = misalign ? 4'd0 : 4'(WAIT_CYCLES);
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                state_d = cnt == 4'd1 ? ACCESS : WAIT;
            end
            ACCESS: state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            cnt <= cnt_d;
            if (state == IDLE && Req_valid) begin
                write_q <= Req_write;
                dw_q <= Req_dw;
                byte_q <= Req_byte;
                adrs_q <= Adrs[AW+1:0];
                wdata_q <= Wdata;
                wdata64_q <= Wdata64;
                err_q <= misalign;
            end
        end
    end

    // Array has no reset so its contents survive Rst.
    always_ff @(posedge Clk) begin
        if (!Rst && state == ACCESS && write_q) begin
            if (dw_q) begin
                mem[idx] <= wdata64_q[63:32];
                mem[idx_n] <= wdata64_q[31:0];
            end else if (byte_q) begin
                mem[idx][{~adrs_q[1:0], 3'b111} -: 8] <= wdata_q[7:0];
            end else begin
                mem[idx] <= wdata_q;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            Rdata <= 32'd0;
            Rdata_next <= 32'd0;
        end else if (state == ACCESS && !write_q) begin
            Rdata <= mem[idx];
            Rdata_next <= mem[idx_n];
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed table-driven bench for data_mem_responder.
// Expectations for misaligned requests follow MEM_MISALIGN_TRAP_EN.
module tb_data_mem_responder;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif
    logic Clk = 1'b0, Rst = 1'b1, Req_valid = 1'b0, Req_valid0 = 1'b0;
    logic Req_write = 1'b0, Req_dw = 1'b0, Req_byte = 1'b0;
    logic [31:0] Adrs = 32'd0, Wdata = 32'd0;
    logic [63:0] Wdata64 = 64'd0;
    logic [31:0] Rdata, Rdata_next, Rdata0, Rdata_next0;
    logic Busy, Resp_valid, Resp_err, Busy0, Resp_valid0, Resp_err0;
    int n_chk = 0, n_fail = 0;

    always #5 Clk = ~Clk;

    data_mem_responder dut (
        .Clk(Clk), .Rst(Rst), .Req_valid(Req_valid), .Req_write(Req_write),
        .Req_dw(Req_dw), .Req_byte(Req_byte), .Adrs(Adrs), .Wdata(Wdata),
        .Wdata64(Wdata64), .Rdata(Rdata), .Rdata_next(Rdata_next),
        .Busy(Busy), .Resp_valid(Resp_valid), .Resp_err(Resp_err)
    );

    data_mem_responder #(.DEPTH(8), .WAIT_CYCLES(0)) dut0 (
        .Clk(Clk), .Rst(Rst), .Req_valid(Req_valid0), .Req_write(Req_write),
        .Req_dw(Req_dw), .Req_byte(Req_byte), .Adrs(Adrs), .Wdata(Wdata),
        .Wdata64(Wdata64), .Rdata(Rdata0), .Rdata_next(Rdata_next0),
        .Busy(Busy0), .Resp_valid(Resp_valid0), .Resp_err(Resp_err0)
    );

    typedef struct {
        logic w, dw, by;
        logic [31:0] a, wd;
        logic [63:0] wd64;
        logic [31:0] rd, rn;
        logic err;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req(input logic sel, input logic w, input logic dw, input logic by,
                       input logic [31:0] a, input logic [31:0] wd, input logic [63:0] wd64,
                       output int lat, output int busy_n, output logic err);
        @(negedge Clk);
        Req_write = w; Req_dw = dw; Req_byte = by; Adrs = a; Wdata = wd; Wdata64 = wd64;
        if (sel) Req_valid0 = 1'b1; else Req_valid = 1'b1;
        @(posedge Clk);
        #1;
        Req_valid = 1'b0;
        Req_valid0 = 1'b0;
        lat = 0;
        busy_n = 0;
        err = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (sel ? Busy0 : Busy) busy_n++;
            if (sel ? Resp_valid0 : Resp_valid) begin
                lat = i;
                err = sel ? Resp_err0 : Resp_err;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, busy_n, np, exp_lat;
        int p [4];
        logic err, seen;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h14, 32'h01234567, 64'h0, 32'h0, 32'h0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, 64'h0, 32'h0, 32'h0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 64'h0, 32'hDEADBEEF, 32'h01234567, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h3FC, 32'h0, 64'h11112222_33334444, 32'hDEADBEEF, 32'h01234567, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0, 64'h0, 32'h11112222, 32'h33334444, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 32'hFFFFF3FC, 32'h0, 64'h0, 32'h11112222, 32'h33334444, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 64'h0, 32'h11112222, 32'h33334444, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 32'h24, 32'hCAFEF00D, 64'h0, 32'h11112222, 32'h33334444, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 32'h21, 32'h000000AA, 64'h0, 32'h11112222, 32'h33334444, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h23, 32'hFFFFFF55, 64'h0, 32'h11112222, 32'h33334444, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 64'h0, 32'h00AA0055, 32'hCAFEF00D, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h20, 32'h0, 64'h0, 32'h00AA0055, 32'hCAFEF00D, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 32'h20, 32'h0, 64'hA5A5A5A5_5A5A5A5A, 32'h00AA0055, 32'hCAFEF00D, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 64'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 32'h22, 32'h0BADCAFE, 64'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, TRAP};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h20, 32'h0, 64'h0, TRAP ? 32'hA5A5A5A5 : 32'h0BADCAFE, 32'h5A5A5A5A, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h22, 32'h0, 64'h0, TRAP ? 32'hA5A5A5A5 : 32'h0BADCAFE, 32'h5A5A5A5A, TRAP};

        // Requests held high during reset must be ignored.
        Req_valid = 1'b1;
        Req_valid0 = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        Req_valid = 1'b0;
        Req_valid0 = 1'b0;
        Rst = 1'b0;
        @(negedge Clk);
        chk("rst_busy", Busy, 0);
        chk("rst_resp_valid", Resp_valid, 0);
        chk("rst_resp_err", Resp_err, 0);
        chk("rst_rdata", Rdata, 0);
        chk("rst_rdata_next", Rdata_next, 0);
        chk("rst_busy0", Busy0, 0);

        for (int i = 0; i < 17; i++) begin
            req(1'b0, tbl[i].w, tbl[i].dw, tbl[i].by, tbl[i].a, tbl[i].wd, tbl[i].wd64, lat, busy_n, err);
            exp_lat = tbl[i].err ? 1 : 4;
            chk($sformatf("row%0d_latency", i), lat, exp_lat);
            chk($sformatf("row%0d_busy_cycles", i), busy_n, exp_lat);
            chk($sformatf("row%0d_resp_err", i), err, tbl[i].err);
            chk($sformatf("row%0d_rdata", i), Rdata, tbl[i].rd);
            chk($sformatf("row%0d_rdata_next", i), Rdata_next, tbl[i].rn);
            @(negedge Clk);
            chk($sformatf("row%0d_idle_after", i), Busy, 0);
        end

        // Second request (a write) held high while busy must be dropped.
        @(negedge Clk);
        Req_write = 1'b0; Req_dw = 1'b0; Req_byte = 1'b0; Adrs = 32'h10; Req_valid = 1'b1;
        @(posedge Clk);
        #1;
        Req_write = 1'b1;
        Wdata = 32'h0;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge Clk);
            if (Resp_valid) begin
                lat = i;
                Req_valid = 1'b0;
                break;
            end
        end
        Req_valid = 1'b0;
        chk("busy_ignore_latency", lat, 4);
        chk("busy_ignore_rdata", Rdata, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk($sformatf("busy_ignore_idle%0d", i), Busy, 0);
        end
        req(1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 64'h0, lat, busy_n, err);
        chk("busy_ignore_reread", Rdata, 32'hDEADBEEF);

        // Reset during WAIT of a write must cancel it.
        req(1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h30303030, 64'h0, lat, busy_n, err);
        req(1'b0, 1'b1, 1'b0, 1'b0, 32'h34, 32'h34343434, 64'h0, lat, busy_n, err);
        @(negedge Clk);
        Req_write = 1'b1; Req_dw = 1'b0; Req_byte = 1'b0; Adrs = 32'h30; Wdata = 32'hFFFFFFFF; Req_valid = 1'b1;
        @(posedge Clk);
        #1;
        Req_valid = 1'b0;
        @(negedge Clk);
        chk("pre_rst_busy", Busy, 1);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_rdata", Rdata, 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge Clk);
            if (Resp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_resp", seen, 0);
        req(1'b0, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 64'h0, lat, busy_n, err);
        chk("mid_rst_mem_kept", Rdata, 32'h30303030);
        chk("mid_rst_mem_next", Rdata_next, 32'h34343434);

        // Zero-wait instance: latency, wrap and back-to-back throughput.
        req(1'b1, 1'b1, 1'b1, 1'b0, 32'h1C, 32'h0, 64'hAAAABBBB_CCCCDDDD, lat, busy_n, err);
        chk("w0_latency", lat, 2);
        chk("w0_busy_cycles", busy_n, 2);
        @(negedge Clk);
        Req_write = 1'b0; Req_dw = 1'b0; Req_byte = 1'b0; Adrs = 32'h1C; Req_valid0 = 1'b1;
        np = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge Clk);
            if (Resp_valid0) begin
                if (np < 4) p[np] = i;
                np++;
            end
        end
        Req_valid0 = 1'b0;
        chk("w0_pulse_count", np, 4);
        chk("w0_first_pulse", p[0], 2);
        for (int k = 0; k < 3; k++)
            chk($sformatf("w0_gap%0d", k), p[k+1] - p[k], 3);
        chk("w0_rdata", Rdata0, 32'hAAAABBBB);
        chk("w0_rdata_next", Rdata_next0, 32'hCCCCDDDD);

        repeat (2) @(negedge Clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
